// File: rtl/shift_issue_stage_if.sv
// Handshake bundle between the decode/register-read side and the shifter.
// slave = issue stage view, master = producer/consumer (bench) view.
interface shift_issue_stage_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] rdest_data;
  logic [WIDTH-1:0] rsrc_data;
  logic [3:0]       op_code;
  logic [3:0]       op_ext;
  logic [3:0]       amount;
  logic [WIDTH-1:0] a_out;
  logic [3:0]       dest;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  instr, instr_valid, rdest_data, rsrc_data, out_ready,
    output instr_ready, op_code, op_ext, amount, a_out, dest, out_valid
  );

  modport master (
    output instr, instr_valid, rdest_data, rsrc_data, out_ready,
    input  instr_ready, op_code, op_ext, amount, a_out, dest, out_valid
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes LSH/LSHI/LUI, two-entry (output + skid) in-order buffer.
// Optional macro SHIFT_ISSUE_PERF_EN adds a saturating consumed-shift counter.
module shift_issue_stage #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  shift_issue_stage_if.slave   bus
`ifdef SHIFT_ISSUE_PERF_EN
  ,
  output logic [15:0]          shift_count
`endif
);
  // Packed operation: {op_code, op_ext, amount, dest, a_out}
  localparam int OPW = 16 + WIDTH;

  logic [3:0]     w_opc;
  logic [3:0]     w_ext;
  logic           w_is_lui;
  logic           w_is_shift;
  logic [3:0]     w_amt;
  logic [WIDTH-1:0] w_a;
  logic [OPW-1:0] w_new_op;
  logic           w_accept;
  logic           w_push;
  logic           w_consume;
  logic           w_unused_bits;

  logic           r_out_valid;
  logic [OPW-1:0] r_out_op;
  logic           r_skid_full;
  logic [OPW-1:0] r_skid_op;

  assign w_opc      = bus.instr[15:12];
  assign w_ext      = bus.instr[7:4];
  assign w_is_lui   = (w_opc == 4'hF);
  assign w_is_shift = w_is_lui ||
                      ((w_opc == 4'h8) &&
                       ((w_ext == 4'h0) || (w_ext == 4'h1) || (w_ext == 4'h4)));

  always_comb begin
    w_amt = bus.instr[3:0];
    w_a   = bus.rdest_data;
    if (w_is_lui) begin
      w_amt = 4'd0;
      w_a   = {{(WIDTH-8){1'b0}}, bus.instr[7:0]};
    end else if (w_ext == 4'h4) begin
      w_amt = bus.rsrc_data[3:0];
    end
  end

  assign w_new_op      = {w_opc, w_ext, w_amt, bus.instr[11:8], w_a};
  assign w_unused_bits = ^bus.rsrc_data[WIDTH-1:4];

  // Non-shift instructions are still accepted, they just never enter the buffer.
  assign w_accept  = bus.instr_valid && !r_skid_full;
  assign w_push    = w_accept && w_is_shift;
  assign w_consume = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_skid_full <= 1'b0;
      r_skid_op   <= '0;
    end else if (w_consume || !r_out_valid) begin
      // Output slot frees up this cycle: skid has priority to keep order.
      if (r_skid_full) begin
        r_out_op    <= r_skid_op;
        r_out_valid <= 1'b1;
        r_skid_full <= 1'b0;
      end else if (w_push) begin
        r_out_op    <= w_new_op;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_push) begin
      r_skid_op   <= w_new_op;
      r_skid_full <= 1'b1;
    end
  end

  assign bus.instr_ready = !r_skid_full;
  assign bus.out_valid   = r_out_valid;
  assign bus.op_code     = r_out_op[OPW-1 -: 4];
  assign bus.op_ext      = r_out_op[OPW-5 -: 4];
  assign bus.amount      = r_out_op[OPW-9 -: 4];
  assign bus.dest        = r_out_op[OPW-13 -: 4];
  assign bus.a_out       = r_out_op[WIDTH-1:0];

`ifdef SHIFT_ISSUE_PERF_EN
  logic [15:0] r_shift_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift_count <= 16'h0000;
    end else if (w_consume && (r_shift_count != 16'hFFFF)) begin
      r_shift_count <= r_shift_count + 16'd1;
    end
  end

  assign shift_count = r_shift_count;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed cases then random traffic vs. a queue model.
module tb_shift_issue_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  typedef struct packed {
    logic [3:0]  opc;
    logic [3:0]  ext;
    logic [3:0]  amt;
    logic [3:0]  dst;
    logic [15:0] a;
  } op_t;

  op_t q[$];
  int  model_count = 0;

  shift_issue_stage_if #(.WIDTH(16)) bus ();

`ifdef SHIFT_ISSUE_PERF_EN
  logic [15:0] shift_count;
  shift_issue_stage #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .shift_count(shift_count)
  );
`else
  shift_issue_stage #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction semantics straight from the ISA field definitions.
  function automatic bit ref_decode(input logic [15:0] ins, input logic [15:0] rd,
                                    input logic [15:0] rs, output op_t op);
    op.opc = ins[15:12];
    op.ext = ins[7:4];
    op.dst = ins[11:8];
    op.a   = rd;
    op.amt = ins[3:0];
    if (ins[15:12] == 4'hF) begin
      op.a   = {8'h00, ins[7:0]};
      op.amt = 4'd0;
      return 1'b1;
    end
    if (ins[15:12] == 4'h8 && (ins[7:4] == 4'h0 || ins[7:4] == 4'h1)) return 1'b1;
    if (ins[15:12] == 4'h8 && ins[7:4] == 4'h4) begin
      op.amt = rs[3:0];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("op_code", {28'd0, bus.op_code}, {28'd0, q[0].opc});
      chk("op_ext",  {28'd0, bus.op_ext},  {28'd0, q[0].ext});
      chk("amount",  {28'd0, bus.amount},  {28'd0, q[0].amt});
      chk("dest",    {28'd0, bus.dest},    {28'd0, q[0].dst});
      chk("a_out",   {16'd0, bus.a_out},   {16'd0, q[0].a});
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] rd,
                      input logic [15:0] rs, input logic ordy);
    op_t op;
    bit  is_shift;
    bit  cons;
    bit  acc;
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.rdest_data  = rd;
    bus.rsrc_data   = rs;
    bus.out_ready   = ordy;
    chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, q.size() < 2});
    is_shift = ref_decode(ins, rd, rs, op);
    cons = (q.size() > 0) && ordy;
    acc  = v && (q.size() < 2);
    @(posedge clk);
    if (cons) begin
      void'(q.pop_front());
      if (model_count < 16'hFFFF) model_count++;
    end
    if (acc && is_shift) q.push_back(op);
    #1;
    $display("t=%0t v=%0b instr=%h ordy=%0b acc=%0b cons=%0b depth=%0d",
             $time, v, ins, ordy, acc, cons, q.size());
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ready",     {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_fields", {bus.op_code, bus.op_ext, bus.amount, bus.dest, bus.a_out}, 32'd0);
`ifdef SHIFT_ISSUE_PERF_EN
    chk("rst_count", {16'd0, shift_count}, 32'd0);
`endif
  endtask

  initial begin
    logic [3:0] opc;
    logic [3:0] ext;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.rdest_data  = '0;
    bus.rsrc_data   = '0;
    bus.out_ready   = 1'b0;

    #2;
    check_reset_values();
    @(negedge clk);
    reset_n = 1'b1;

    // LSHI, LSH, LUI each with a free output register
    step(1'b1, 16'h8301, 16'h00F0, 16'h0000, 1'b1);
    step(1'b1, 16'h8545, 16'h1234, 16'h000C, 1'b1);
    step(1'b1, 16'hF2AB, 16'h5555, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    // non-shift instruction is swallowed
    step(1'b1, 16'h0123, 16'hBEEF, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);

    // stall: three back-to-back, third refused; then drain in order
    step(1'b1, 16'h8101, 16'h0001, 16'h0000, 1'b0);
    step(1'b1, 16'h8244, 16'h0002, 16'h0003, 1'b0);
    step(1'b1, 16'hF3CD, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'hF3CD, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);

    // two buffered then asynchronous reset mid-operation
    step(1'b1, 16'h8711, 16'hAAAA, 16'h0000, 1'b0);
    step(1'b1, 16'h8804, 16'hBBBB, 16'h0000, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    q.delete();
    model_count = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: opc = 4'hF;
        1, 2: opc = 4'h8;
        default: opc = 4'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: ext = 4'h0;
        1: ext = 4'h1;
        2: ext = 4'h4;
        default: ext = 4'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, {opc, 4'($urandom), ext, 4'($urandom)},
           16'($urandom), 16'($urandom), $urandom_range(0, 9) < 6);
    end

`ifdef SHIFT_ISSUE_PERF_EN
    chk("shift_count", {16'd0, shift_count}, model_count);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width of operand and instruction word.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr  input  WIDTH  instruction word: [15:12] opCode, [11:8] Rdest, [7:4] opCodeExt, [3:0] Rsrc/Imm.
REQ-005 instr_valid  input  1  instr, rdest_data and rsrc_data are valid this cycle.
REQ-006 instr_ready  output  1  stage accepts an instruction this cycle.
REQ-007 rdest_data  input  WIDTH  register-file value of Rdest, same cycle as instr.
REQ-008 rsrc_data  input  WIDTH  register-file value of Rsrc, same cycle as instr.
REQ-009 op_code, op_ext  output  4 each  decoded opCode/opCodeExt for the shifter.
REQ-010 amount  output  4  shift amount for the shifter.
REQ-011 a_out  output  WIDTH  operand A for the shifter.
REQ-012 dest  output  4  writeback register index.
REQ-013 out_valid  output  1  output fields hold an issued shift operation.
REQ-014 out_ready  input  1  downstream consumes the operation this cycle.

Function
REQ-015 An instruction is accepted when instr_valid && instr_ready; an output is consumed when out_valid && out_ready.
REQ-016 Shift class: opCode 4'b1000 with opCodeExt in {0000, 0001, 0100}, and opCode 4'b1111 (LUI); every other accepted instruction is discarded: no output, no stall.
REQ-017 LSH register (1000/0100): a_out = rdest_data, amount = rsrc_data[3:0].
REQ-018 LSHI (1000/000s): a_out = rdest_data, amount = instr[3:0].
REQ-019 LUI (1111): a_out = {8'h00, instr[7:0]}, amount = 4'd0.
REQ-020 All outputs are registered; accept-to-out_valid latency is 1 cycle when the output register is free or is being consumed the same cycle.
REQ-021 Buffering: one output register plus one skid register; capacity of 2 shift operations; strict in-order delivery.
REQ-022 instr_ready = NOT skid_full, derived from a register only (no combinational path from out_ready).
REQ-023 Accept while output register stalled (out_valid && !out_ready): operation goes to the skid register; skid_full = 1 next cycle.
REQ-024 Consume with skid full: skid contents move to the output register next cycle; skid_full clears.
REQ-025 Consume with skid empty and simultaneous accept: the new operation loads the output register; out_valid stays 1.
REQ-026 Consume with no accept and skid empty: out_valid = 0 next cycle.
REQ-027 Output fields remain stable while out_valid && !out_ready.
REQ-028 A discarded (non-shift) instruction is accepted under the same instr_ready rule and does not alter buffer state.

Reset
REQ-029 On reset_n low, immediately: out_valid = 0, skid_full = 0, op_code/op_ext/amount/dest = 0, a_out = 0; instr_ready = 1 after reset.
REQ-030 Reset asserted mid-operation discards both buffered operations; no output is presented after reset release until a new acceptance.

Configuration
REQ-031 Macro SHIFT_ISSUE_PERF_EN defined: adds output shift_count (16 bits), incremented on each consumed shift operation, saturating at 16'hFFFF, reset to 0.
REQ-032 SHIFT_ISSUE_PERF_EN undefined: no shift_count port or counter logic; all other behaviour identical.

Verification
REQ-033 Accept instr 16'h8301 (LSHI right, R3, imm 1), rdest_data 16'h00F0, out_ready=1 -> next cycle out_valid=1, op_code=8, op_ext=0, amount=1, a_out=16'h00F0, dest=3.
REQ-034 Accept 16'h8545 (LSH, R5, Rsrc 5), rsrc_data 16'h000C -> amount=4'hC, op_ext=4'h4, a_out=rdest_data.
REQ-035 Accept 16'hF2AB (LUI, R2) -> a_out=16'h00AB, amount=0, op_code=4'hF, dest=2.
REQ-036 Hold out_ready=0, issue three back-to-back shift instructions -> first two accepted, instr_ready=0 from third cycle; release out_ready -> delivered in order, instr_ready returns 1.
REQ-037 Accept 16'h0123 (non-shift) -> out_valid stays 0, instr_ready stays 1.
REQ-038 Two operations buffered, pulse reset_n low -> out_valid=0, instr_ready=1 immediately; with SHIFT_ISSUE_PERF_EN, shift_count=0.
